// File: rtl/batch_norm_pkg.sv
// Shared types and sizing helpers for the batch-norm lane sequencer.
package batch_norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FILTERS    = 64;
  localparam int unsigned DEF_INPUT      = 30;
  localparam int unsigned DEF_PARAM_LAT  = 1;

  // {gamma, beta} word layout: gamma occupies the upper half.
  localparam int unsigned GAMMA_SLOT = 1;
  localparam int unsigned BETA_SLOT  = 0;

  function automatic int unsigned pix_count(input int unsigned side);
    return side * side;
  endfunction

  // Counter width for a range of n values, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bn_param_fetch.sv
// Parameter-fetch timing: read strobe, PARAM_LAT wait counter and gamma/beta capture.
module bn_param_fetch
  import batch_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PARAM_LAT  = DEF_PARAM_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    wait_en,
  input  logic                    abort,
  input  logic [2*DATA_WIDTH-1:0] param_data,
  output logic                    param_rd,
  output logic [DATA_WIDTH-1:0]   gamma,
  output logic [DATA_WIDTH-1:0]   beta,
  output logic                    params_ready_c
);

  localparam int unsigned LW = cnt_width(PARAM_LAT);

  logic [LW-1:0] wait_q;
  logic          last_c;

  assign param_rd       = load;
  assign last_c         = (wait_q == LW'(PARAM_LAT - 1));
  assign params_ready_c = wait_en && last_c;

  // Abort drops the outstanding read; gamma/beta keep their last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      gamma  <= '0;
      beta   <= '0;
    end else if (abort) begin
      wait_q <= '0;
    end else if (wait_en) begin
      if (last_c) begin
        wait_q <= '0;
        gamma  <= param_data[GAMMA_SLOT*DATA_WIDTH +: DATA_WIDTH];
        beta   <= param_data[BETA_SLOT*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        wait_q <= wait_q + LW'(1);
      end
    end
  end

endmodule

// File: rtl/batch_norm_controller.sv
// Filter/pixel sequencer for the shared BN datapath lane.
// Optional BN_CTRL_STALL_CNT_EN adds a 32-bit stall_cycles backpressure counter.
module batch_norm_controller
  import batch_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FILTERS    = DEF_FILTERS,
  parameter int unsigned INPUT      = DEF_INPUT,
  parameter int unsigned PARAM_LAT  = DEF_PARAM_LAT,
  localparam int unsigned P         = pix_count(INPUT),
  localparam int unsigned FW        = cnt_width(FILTERS),
  localparam int unsigned PW        = cnt_width(P),
  localparam int unsigned EW        = cnt_width(FILTERS * P)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    param_rd,
  output logic [FW-1:0]           param_addr,
  input  logic [2*DATA_WIDTH-1:0] param_data,
  output logic [DATA_WIDTH-1:0]   gamma,
  output logic [DATA_WIDTH-1:0]   beta,
  output logic                    elem_valid,
  input  logic                    elem_ready,
  output logic [EW-1:0]           elem_addr,
  output logic                    elem_last,
  output logic                    busy,
  output logic                    done
`ifdef BN_CTRL_STALL_CNT_EN
  , output logic [31:0]           stall_cycles
`endif
);

  state_e        state_q, state_d;
  logic [FW-1:0] filter_q, filter_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [EW-1:0] elem_q, elem_d;
  logic          params_ready_c;
  logic          pixel_last_c;
  logic          filter_last_c;
  logic          accept_start_c;

  assign pixel_last_c   = (pixel_q == PW'(P - 1));
  assign filter_last_c  = (filter_q == FW'(FILTERS - 1));
  assign accept_start_c = (state_q == S_IDLE) && start && !abort;

  bn_param_fetch #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARAM_LAT  (PARAM_LAT)
  ) u_fetch (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (state_q == S_LOAD),
    .wait_en        (state_q == S_WAIT),
    .abort          (abort),
    .param_data     (param_data),
    .param_rd       (param_rd),
    .gamma          (gamma),
    .beta           (beta),
    .params_ready_c (params_ready_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      filter_q <= '0;
      pixel_q  <= '0;
      elem_q   <= '0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      pixel_q  <= pixel_d;
      elem_q   <= elem_d;
    end
  end

  // elem_q tracks filter*P+pixel incrementally, so no multiplier is needed.
  always_comb begin
    state_d  = state_q;
    filter_d = filter_q;
    pixel_d  = pixel_q;
    elem_d   = elem_q;
    case (state_q)
      S_IDLE: begin
        if (accept_start_c) begin
          state_d  = S_LOAD;
          filter_d = '0;
          pixel_d  = '0;
          elem_d   = '0;
        end
      end
      S_LOAD:  state_d = S_WAIT;
      S_WAIT:  if (params_ready_c) state_d = S_STREAM;
      S_STREAM: begin
        if (elem_ready) begin
          if (!pixel_last_c) begin
            pixel_d = pixel_q + PW'(1);
            elem_d  = elem_q + EW'(1);
          end else if (!filter_last_c) begin
            pixel_d  = '0;
            filter_d = filter_q + FW'(1);
            elem_d   = elem_q + EW'(1);
            state_d  = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        filter_d = '0;
        pixel_d  = '0;
        elem_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      filter_d = '0;
      pixel_d  = '0;
      elem_d   = '0;
    end
  end

  assign param_addr = filter_q;
  assign elem_valid = (state_q == S_STREAM);
  assign elem_addr  = elem_q;
  assign elem_last  = (state_q == S_STREAM) && pixel_last_c;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

`ifdef BN_CTRL_STALL_CNT_EN
  // Saturating count of STREAM cycles the datapath refused an element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (accept_start_c) begin
      stall_cycles <= '0;
    end else if ((state_q == S_STREAM) && !elem_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_batch_norm_controller.sv
// Self-checking bench for batch_norm_controller (FILTERS=2, INPUT=2; PARAM_LAT 1 and 3).
module tb_batch_norm_controller;

  localparam logic [31:0] G0 = 32'h3F800000;
  localparam logic [31:0] B0 = 32'h00000010;
  localparam logic [31:0] G1 = 32'h40000000;
  localparam logic [31:0] B1 = 32'hFFFFFFF0;

  typedef struct {
    logic [2:0]  addr;
    logic        last;
    logic [31:0] g;
    logic [31:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with PARAM_LAT=1
  logic        start, abort, elem_ready;
  logic        param_rd, elem_valid, elem_last, busy, done;
  logic [0:0]  param_addr;
  logic [63:0] param_data;
  logic [31:0] gamma, beta;
  logic [2:0]  elem_addr;
  // DUT with PARAM_LAT=3
  logic        start3, abort3, elem_ready3;
  logic        param_rd3, elem_valid3, elem_last3, busy3, done3;
  logic [0:0]  param_addr3;
  logic [63:0] param_data3, p3a, p3b;
  logic [31:0] gamma3, beta3;
  logic [2:0]  elem_addr3;
`ifdef BN_CTRL_STALL_CNT_EN
  logic [31:0] stall0, stall3;
`endif

  exp_t sb[$];
  exp_t sb3[$];
  int   errors = 0;
  int   checks = 0;

  batch_norm_controller #(.DATA_WIDTH(32), .FILTERS(2), .INPUT(2), .PARAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .param_rd(param_rd), .param_addr(param_addr), .param_data(param_data),
    .gamma(gamma), .beta(beta), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_addr(elem_addr), .elem_last(elem_last), .busy(busy), .done(done)
`ifdef BN_CTRL_STALL_CNT_EN
    , .stall_cycles(stall0)
`endif
  );

  batch_norm_controller #(.DATA_WIDTH(32), .FILTERS(2), .INPUT(2), .PARAM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .param_rd(param_rd3), .param_addr(param_addr3), .param_data(param_data3),
    .gamma(gamma3), .beta(beta3), .elem_valid(elem_valid3), .elem_ready(elem_ready3),
    .elem_addr(elem_addr3), .elem_last(elem_last3), .busy(busy3), .done(done3)
`ifdef BN_CTRL_STALL_CNT_EN
    , .stall_cycles(stall3)
`endif
  );

  function automatic logic [63:0] pmem(input logic a);
    return a ? {G1, B1} : {G0, B0};
  endfunction

  // Parameter memories: 1-cycle and 3-cycle read latency.
  always @(posedge clk) begin
    param_data  <= param_rd ? pmem(param_addr[0]) : 64'd0;
    p3a         <= param_rd3 ? pmem(param_addr3[0]) : 64'd0;
    p3b         <= p3a;
    param_data3 <= p3b;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input bit lat3);
    exp_t e;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) begin
        e.addr = 3'(f * 4 + p);
        e.last = (p == 3);
        e.g    = (f == 0) ? G0 : G1;
        e.b    = (f == 0) ? B0 : B1;
        if (lat3) sb3.push_back(e);
        else sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if ({param_rd, param_addr, gamma, beta, elem_valid, elem_addr, elem_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b pa=%0d g=%h b=%h v=%b a=%0d l=%b busy=%b done=%b, want all 0",
               param_rd, param_addr, gamma, beta, elem_valid, elem_addr, elem_last, busy, done);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if ({busy, done, elem_valid, param_rd, busy3} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b v=%b rd=%b busy3=%b, want 0", busy, done, elem_valid, param_rd, busy3);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   hs = 0;
    logic eb, er, ev, el, ed;
    int   ea;
    push_run(1'b0);
    cyc();
    start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      eb = (c >= 1 && c <= 13);
      er = (c == 1 || c == 7);
      ev = (c >= 3 && c <= 6) || (c >= 9 && c <= 12);
      el = (c == 6 || c == 12);
      ed = (c == 13);
      ea = (c <= 6) ? c - 3 : c - 5;
      checks++;
      if ({busy, param_rd, elem_valid, elem_last, done} !== {eb, er, ev, el, ed}) begin
        errors++;
        $display("FAIL basic_ctrl c=%0d: busy/rd/v/last/done=%b%b%b%b%b want %b%b%b%b%b",
                 c, busy, param_rd, elem_valid, elem_last, done, eb, er, ev, el, ed);
      end
      if (er) begin
        checks++;
        if (param_addr !== 1'(c >= 7)) begin
          errors++;
          $display("FAIL basic_param_addr c=%0d: got %0d want %0d", c, param_addr, (c >= 7));
        end
      end
      if (ev) begin
        checks++;
        if ({elem_addr, gamma, beta} !== {3'(ea), (c <= 6) ? G0 : G1, (c <= 6) ? B0 : B1}) begin
          errors++;
          $display("FAIL basic_stream c=%0d: addr=%0d g=%h b=%h want addr=%0d g=%h b=%h",
                   c, elem_addr, gamma, beta, ea, (c <= 6) ? G0 : G1, (c <= 6) ? B0 : B1);
        end
      end
      if (elem_valid && elem_ready) begin
        hs++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow basic: addr=%0d unexpected", elem_addr);
        end else begin
          e = sb.pop_front();
          if ({elem_addr, elem_last, gamma, beta} !== {e.addr, e.last, e.g, e.b}) begin
            errors++;
            $display("FAIL sb_elem basic: got a=%0d l=%b g=%h b=%h want a=%0d l=%b g=%h b=%h",
                     elem_addr, elem_last, gamma, beta, e.addr, e.last, e.g, e.b);
          end
        end
      end
      cyc();
      start = 1'b0;
    end
    checks++;
    if (hs != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_total: handshakes=%0d left=%0d want 8 and 0", hs, sb.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   held = 0, done_cyc = -1;
    push_run(1'b0);
    cyc();
    start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      elem_ready = !(elem_valid && elem_addr == 3'd2 && held < 3);
      if (!elem_ready) held++;
      @(negedge clk);
      if (!elem_ready) begin
        checks++;
        if (elem_valid !== 1'b1 || elem_addr !== 3'd2) begin
          errors++;
          $display("FAIL bp_hold c=%0d: v=%b addr=%0d want v=1 addr=2", c, elem_valid, elem_addr);
        end
      end
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow bp: addr=%0d unexpected", elem_addr);
        end else begin
          e = sb.pop_front();
          if ({elem_addr, elem_last, gamma, beta} !== {e.addr, e.last, e.g, e.b}) begin
            errors++;
            $display("FAIL sb_elem bp: got a=%0d l=%b g=%h b=%h want a=%0d l=%b g=%h b=%h",
                     elem_addr, elem_last, gamma, beta, e.addr, e.last, e.g, e.b);
          end
        end
      end
      if (done && done_cyc < 0) done_cyc = c;
      cyc();
      start = 1'b0;
    end
    elem_ready = 1'b1;
    checks++;
    if (done_cyc != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_done: done at cycle %0d left=%0d want cycle 16 and 0", done_cyc, sb.size());
    end
`ifdef BN_CTRL_STALL_CNT_EN
    checks++;
    if (stall0 !== 32'd3) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d want 3", stall0);
    end
`endif
  endtask

  task automatic test_abort();
    exp_t e;
    bit   found = 1'b0;
    int   done_cyc = -1;
    push_run(1'b0);
    cyc();
    start = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      if (elem_valid && elem_addr == 3'd5) begin
        abort = 1'b1;
        found = 1'b1;
      end
      @(negedge clk);
      if (elem_valid && elem_ready) begin
        checks++;
        e = sb.pop_front();
        if ({elem_addr, gamma, beta} !== {e.addr, e.g, e.b}) begin
          errors++;
          $display("FAIL sb_elem abort: got a=%0d g=%h b=%h want a=%0d g=%h b=%h",
                   elem_addr, gamma, beta, e.addr, e.g, e.b);
        end
      end
      cyc();
      start = 1'b0;
      abort = 1'b0;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_timeout: elem_addr 5 never seen, got 0 want 1");
    end
    sb.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if ({busy, elem_valid, param_rd} !== 3'b000 || {gamma, beta} !== {G1, B1}) begin
          errors++;
          $display("FAIL abort_idle: busy=%b v=%b rd=%b g=%h b=%h want 000 g=%h b=%h",
                   busy, elem_valid, param_rd, gamma, beta, G1, B1);
        end
      end
      if (done) done_cyc = c;
      cyc();
    end
    checks++;
    if (done_cyc >= 0) begin
      errors++;
      $display("FAIL abort_no_done: done seen at %0d, want none", done_cyc);
    end
    // restart after abort
    push_run(1'b0);
    start = 1'b1;
    done_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (param_rd !== 1'b1 || param_addr !== 1'b0) begin
          errors++;
          $display("FAIL restart_load: rd=%b pa=%0d want rd=1 pa=0", param_rd, param_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (elem_valid !== 1'b1 || elem_addr !== 3'd0) begin
          errors++;
          $display("FAIL restart_stream: v=%b addr=%0d want v=1 addr=0", elem_valid, elem_addr);
        end
      end
      if (elem_valid && elem_ready && sb.size() > 0) e = sb.pop_front();
      if (done && done_cyc < 0) done_cyc = c;
      cyc();
      start = 1'b0;
    end
    checks++;
    if (done_cyc != 13 || sb.size() != 0) begin
      errors++;
      $display("FAIL restart_done: done at %0d left=%0d want 13 and 0", done_cyc, sb.size());
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int   hs = 0, dn = 0, bc = 0;
    push_run(1'b0);
    cyc();
    for (int c = 0; c < 22; c++) begin
      start = (c == 0 || c == 4 || c == 8 || c == 13);
      @(negedge clk);
      if (busy) bc++;
      if (done) dn++;
      if (elem_valid && elem_ready) begin
        hs++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow start_ignored: addr=%0d unexpected", elem_addr);
        end else begin
          e = sb.pop_front();
          if ({elem_addr, elem_last} !== {e.addr, e.last}) begin
            errors++;
            $display("FAIL sb_elem start_ignored: got a=%0d l=%b want a=%0d l=%b",
                     elem_addr, elem_last, e.addr, e.last);
          end
        end
      end
      cyc();
    end
    start = 1'b0;
    checks++;
    if (dn != 1 || hs != 8 || bc != 13) begin
      errors++;
      $display("FAIL start_ignored: done=%0d hs=%0d busy_cycles=%0d want 1 8 13", dn, hs, bc);
    end
  endtask

  task automatic test_lat3();
    exp_t e;
    int   hs = 0, bc = 0, first = -1, dc = -1;
    push_run(1'b1);
    cyc();
    start3 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (busy3) bc++;
      if (elem_valid3 && first < 0) first = c;
      if (done3 && dc < 0) dc = c;
      if (elem_valid3 && elem_ready3) begin
        hs++;
        checks++;
        if (sb3.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow lat3: addr=%0d unexpected", elem_addr3);
        end else begin
          e = sb3.pop_front();
          if ({elem_addr3, elem_last3, gamma3, beta3} !== {e.addr, e.last, e.g, e.b}) begin
            errors++;
            $display("FAIL sb_elem lat3: got a=%0d l=%b g=%h b=%h want a=%0d l=%b g=%h b=%h",
                     elem_addr3, elem_last3, gamma3, beta3, e.addr, e.last, e.g, e.b);
          end
        end
      end
      cyc();
      start3 = 1'b0;
    end
    checks++;
    if (first != 5 || dc != 17 || bc != 17 || hs != 8) begin
      errors++;
      $display("FAIL lat3_timing: first_valid=%0d done=%0d busy=%0d hs=%0d want 5 17 17 8", first, dc, bc, hs);
    end
  endtask

  task automatic test_reset_mid();
    push_run(1'b0);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({param_rd, gamma, beta, elem_valid, elem_addr, elem_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid: rd=%b g=%h b=%h v=%b a=%0d l=%b busy=%b done=%b want all 0",
               param_rd, gamma, beta, elem_valid, elem_addr, elem_last, busy, done);
    end
    sb.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    elem_ready  = 1'b1;
    start3      = 1'b0;
    abort3      = 1'b0;
    elem_ready3 = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_lat3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
